// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_memory_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker: a lone requester wins, ties go to the pointed port.
module rr_picker2
  import data_memory_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 pointer,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = req[0] & (~req[1] | ~pointer);
    grant[1] = req[1] & (~req[0] | pointer);
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates a CPU port and a DMA port onto one 8-byte-wide data memory,
// one access per IDLE/ACCESS/RESP sequence with range checking.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned SIZE  = 256,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_t                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   lat_we_q, lat_we_d;
  logic                   lat_port_q, lat_port_d;
  logic [WIDTH-1:0]       lat_addr_q, lat_addr_d;
  logic [WIDTH-1:0]       lat_wdata_q, lat_wdata_d;
  logic [WIDTH-1:0]       rdata0_q, rdata1_q;
  logic [NUM_PORTS-1:0]   grant;
  logic                   in_range;

  rr_picker2 u_picker (
    .req     ({req1, req0}),
    .pointer (ptr_q),
    .grant   (grant)
  );

  // One extra bit so the +7 end-of-access address never wraps.
  assign in_range = ({1'b0, lat_addr_q} + (WIDTH+1)'(7)) <= (WIDTH+1)'(SIZE - 1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_we_d    = lat_we_q;
    lat_port_d  = lat_port_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = ACCESS;
          lat_port_d  = grant[1];
          lat_we_d    = grant[1] ? we1 : we0;
          lat_addr_d  = grant[1] ? addr1 : addr0;
          lat_wdata_d = grant[1] ? wdata1 : wdata0;
          ptr_d       = ~grant[1];
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_port_q  <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lat_we_q    <= lat_we_d;
      lat_port_q  <= lat_port_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      if (state_q == ACCESS && !lat_we_q && in_range) begin
        if (lat_port_q) rdata1_q <= mem_rdata;
        else            rdata0_q <= mem_rdata;
      end
    end
  end

  // Reset during RESP drops the ack; the requester re-issues.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    if (state_q == ACCESS) begin
      mem_address = lat_addr_q;
      mem_wdata   = lat_wdata_q;
      mem_write   = lat_we_q & in_range & ~reset;
      mem_read    = ~lat_we_q & in_range;
    end
    if (state_q == RESP && !reset) begin
      ack0 = ~lat_port_q;
      ack1 = lat_port_q;
      err0 = ~lat_port_q & ~in_range;
      err1 = lat_port_q & ~in_range;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a byte-addressed memory model.
module tb_data_memory_arbiter;

  localparam int unsigned SIZE  = 256;
  localparam int unsigned WIDTH = 64;
  localparam logic [63:0] INIT_WORD = 64'h0707070707070707;
  localparam logic [63:0] PAT_A     = 64'h1122334455667788;
  localparam logic [63:0] PAT_B     = 64'hA5A5000012345678;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic             ack0, ack1, err0, err1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             mem_read, mem_write;
  logic [WIDTH-1:0] mem_address, mem_wdata;
  wire  [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] rd_word;

  logic [7:0] mem [SIZE];
  logic       mw_seen, mr_seen;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .err0        (err0),
    .err1        (err1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Little-endian 8-byte word over the byte array; bytes past the end read as 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (mem_address < 64'(SIZE - i)) rd_word[8*i +: 8] = mem[mem_address + 64'(i)];
    end
  end
  assign mem_rdata = mem_read ? rd_word : 'z;

  always @(posedge clock) begin
    if (mem_write) begin
      mw_seen <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (mem_address < 64'(SIZE - i)) mem[mem_address + 64'(i)] <= mem_wdata[8*i +: 8];
      end
    end
    if (mem_read) mr_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic do_access(input logic port, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, output int lat, output logic err,
                           output logic [63:0] rd);
    lat = 99;
    err = 1'bx;
    rd  = 'x;
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (port ? ack1 : ack0) begin
        lat = k;
        err = port ? err1 : err0;
        rd  = port ? rdata1 : rdata0;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
  endtask

  int          lat;
  logic        err;
  logic [63:0] rd;
  int          n_acks;
  int          ack_k [4];
  logic        ack_p [4];
  logic        both_seen;

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 8'h07;
    mw_seen = 1'b0;
    mr_seen = 1'b0;
    reset = 1'b1;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("reset ack0", 64'(ack0), 64'd0);
    check("reset ack1", 64'(ack1), 64'd0);
    check("reset err", 64'({err0, err1}), 64'd0);
    check("reset rdata0", rdata0, 64'd0);
    check("reset rdata1", rdata1, 64'd0);
    check("reset mem strobes", 64'({mem_read, mem_write}), 64'd0);
    check("reset mem_address", mem_address, 64'd0);

    // Port 0 store then load back.
    do_access(1'b0, 1'b1, 64'h10, PAT_A, lat, err, rd);
    check("st0 latency", 64'(lat), 64'd2);
    check("st0 err", 64'(err), 64'd0);
    do_access(1'b0, 1'b0, 64'h10, 64'd0, lat, err, rd);
    check("ld0 latency", 64'(lat), 64'd2);
    check("ld0 err", 64'(err), 64'd0);
    check("ld0 rdata", rd, PAT_A);

    // Port 1 load of untouched memory.
    do_access(1'b1, 1'b0, 64'h40, 64'd0, lat, err, rd);
    check("ld1 latency", 64'(lat), 64'd2);
    check("ld1 rdata", rd, INIT_WORD);
    check("rdata0 held", rdata0, PAT_A);

    // Upper bound: 249 straddles the end, 248 is the last valid word.
    mw_seen = 1'b0;
    do_access(1'b1, 1'b1, 64'd249, PAT_B, lat, err, rd);
    check("st1 249 err", 64'(err), 64'd1);
    check("st1 249 no write", 64'(mw_seen), 64'd0);
    do_access(1'b1, 1'b1, 64'd248, PAT_B, lat, err, rd);
    check("st1 248 err", 64'(err), 64'd0);
    check("st1 248 write", 64'(mw_seen), 64'd1);
    do_access(1'b0, 1'b0, 64'd248, 64'd0, lat, err, rd);
    check("ld0 248 rdata", rd, PAT_B);

    // Reset during the ACCESS cycle of a store aborts it.
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h20; wdata0 = PAT_A;
    @(posedge clock);
    @(negedge clock);
    mw_seen = 1'b0;
    reset = 1'b1;
    req0 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort no write", 64'(mw_seen), 64'd0);
    check("abort rdata0 cleared", rdata0, 64'd0);
    n_acks = 0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      if (ack0 || ack1) n_acks++;
    end
    check("abort no ack", 64'(n_acks), 64'd0);
    do_access(1'b0, 1'b0, 64'h20, 64'd0, lat, err, rd);
    check("abort ld rdata", rd, INIT_WORD);

    // Out-of-range load near the top of the address space.
    do_access(1'b0, 1'b0, 64'h10, 64'd0, lat, err, rd);
    mr_seen = 1'b0;
    do_access(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, lat, err, rd);
    check("oor ld err", 64'(err), 64'd1);
    check("oor ld rdata held", rd, PAT_A);
    check("oor ld no read", 64'(mr_seen), 64'd0);

    // Both ports held from reset: strict alternation, one ack per 3 cycles.
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h40;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_acks = 0;
    both_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ack0 && ack1) both_seen = 1'b1;
      if ((ack0 || ack1) && n_acks < 4) begin
        ack_k[n_acks] = k;
        ack_p[n_acks] = ack1;
        n_acks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr ack count", 64'(n_acks), 64'd4);
    check("rr never both", 64'(both_seen), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < n_acks) begin
        check($sformatf("rr grant %0d port", i), 64'(ack_p[i]), 64'(i % 2));
        check($sformatf("rr grant %0d cycle", i), 64'(ack_k[i]), 64'(2 + 3 * i));
      end
    end
    check("rr rdata0", rdata0, PAT_A);
    check("rr rdata1", rdata1, INIT_WORD);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter SIZE, default 256: byte depth of the attached data memory; used for bounds checks.
REQ-002 Parameter WIDTH, default 64: address and data width in bits.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clock only.
REQ-005 req0, req1  input  1 each  access request; port 0 is the CPU load/store unit, port 1 is the DMA/loader.
REQ-006 we0, we1  input  1 each  1 = 8-byte store, 0 = 8-byte load.
REQ-007 addr0, addr1  input  WIDTH each  byte address of the access.
REQ-008 wdata0, wdata1  input  WIDTH each  store data.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 err0, err1  output  1 each  valid with ack; 1 = out-of-range access, memory untouched.
REQ-011 rdata0, rdata1  output  WIDTH each  registered load data, valid with ack and held until the next ack on that port.
REQ-012 mem_read, mem_write  output  1 each  memory read/write strobes.
REQ-013 mem_address, mem_wdata  output  WIDTH each  memory address and store data.
REQ-014 mem_rdata  input  WIDTH  memory read data; combinational from mem_address; high-Z when mem_read=0.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when req0|req1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 In IDLE with at least one request: select a winner, latch its we/addr/wdata/port id into internal registers, advance to ACCESS.
REQ-017 Arbitration is round-robin: a 1-bit pointer names the preferred port; a lone requester always wins; on simultaneous requests the pointed port wins.
REQ-018 Once a grant is latched, the pointer is set to the other port.
REQ-019 In ACCESS: mem_address = latched address; mem_wdata = latched data; mem_write = latched we & in-range & !reset; mem_read = !latched we & in-range.
REQ-020 In-range means latched address + 7 <= SIZE-1, evaluated at WIDTH+1 bits so no wrap-around occurs; address = 2^WIDTH-1 is out of range.
REQ-021 A store commits in the memory at the posedge ending ACCESS; on that same edge, a load captures mem_rdata into the granted port's rdata register.
REQ-022 In RESP: the granted port's ack = 1 and err = !in-range for exactly one cycle; the other port's ack/err = 0.
REQ-023 An out-of-range load leaves rdata unchanged and asserts err.
REQ-024 Outside ACCESS: mem_read = mem_write = 0, and mem_address/mem_wdata = 0.
REQ-025 Latency: request sampled at edge t, ack high during cycle t+2; a held request is re-served, so the maximum rate is one access per 3 cycles.
REQ-026 Requesters hold req and operands until ack and drop req in the ack cycle unless issuing a new access; a req dropped before grant is ignored without error.
REQ-027 Requests arriving in ACCESS or RESP wait; no request is lost or reordered within a port.

Reset
REQ-028 On reset: state = IDLE; pointer = 0; ack0/1 = 0; err0/1 = 0; rdata0/1 = 0; all latched operands = 0.
REQ-029 Reset asserted during ACCESS suppresses mem_write in that cycle and aborts the access with no ack.
REQ-030 Reset asserted during RESP: the ack is lost; the requester re-issues.

Structure
REQ-031 Package data_memory_arbiter_pkg holds the state encoding (IDLE, ACCESS, RESP) and the constant NUM_PORTS = 2.
REQ-032 One sub-module, rr_picker2: combinational req[1:0] + pointer -> one-hot grant[1:0]; the pointer register stays in the top module.

Verification
REQ-033 Port 0 store addr 0x10, data 0x1122334455667788, then load 0x10 -> ack0 at t+2 each, err0 = 0, rdata0 = 0x1122334455667788.
REQ-034 Port 1 load of never-written addr 0x40 -> rdata1 = 0x0707070707070707 (memory byte init 0x07).
REQ-035 req0 and req1 both held from reset -> grant order 0,1,0,1; acks alternate every 3 cycles.
REQ-036 Port 1 store to addr 249 (SIZE=256) -> ack1 with err1 = 1, mem_write never asserted; store to 248 -> err1 = 0.
REQ-037 reset pulsed in the ACCESS cycle of a port 0 store to 0x20 -> no ack0; subsequent load of 0x20 returns 0x0707070707070707.
REQ-038 Load from addr 0xFFFFFFFFFFFFFFFC -> err = 1, rdata unchanged, mem_read = 0 throughout.
